// File: rtl/enc_4_to_2_pkg.sv
// Shared constants and helpers for the 4-to-2 request priority encoder.
package enc_4_to_2_pkg;

  localparam int unsigned IDX_W = 2;
  localparam int unsigned N_REQ = 4;

  localparam logic [IDX_W-1:0] IDX_A0 = 2'b00;
  localparam logic [IDX_W-1:0] IDX_A1 = 2'b01;
  localparam logic [IDX_W-1:0] IDX_A2 = 2'b10;
  localparam logic [IDX_W-1:0] IDX_A3 = 2'b11;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic multi_hot(input logic [N_REQ-1:0] req);
    logic [N_REQ-1:0] one;
    one = {{(N_REQ-1){1'b0}}, 1'b1};
    return |(req & (req - one));
  endfunction

endpackage

// File: rtl/enc_4_to_2_prio.sv
// Pure combinational priority encode: highest asserted request wins.
module enc_4_to_2_prio
  import enc_4_to_2_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o,
  output logic             multi_o
);

  always_comb begin
    idx_o = IDX_A0;
    if (req_i[3]) begin
      idx_o = IDX_A3;
    end else if (req_i[2]) begin
      idx_o = IDX_A2;
    end else if (req_i[1]) begin
      idx_o = IDX_A1;
    end else begin
      idx_o = IDX_A0;
    end
  end

  assign valid_o = |req_i;
  assign multi_o = multi_hot(req_i);

endmodule

// File: rtl/enc_4_to_2.sv
// 4-input priority encoder with zero-latency outputs and a registered index/valid copy.
module enc_4_to_2
  import enc_4_to_2_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a0,
  input  logic             a1,
  input  logic             a2,
  input  logic             a3,
  output logic [IDX_W-1:0] out,
  output logic             valid,
  output logic             multi,
  output logic [IDX_W-1:0] out_q,
  output logic             valid_q
);

  logic [N_REQ-1:0] req;
  logic [IDX_W-1:0] idx_d, idx_q;
  logic             vld_d, vld_q;

  assign req = {a3, a2, a1, a0};

  enc_4_to_2_prio u_prio (
    .req_i   (req),
    .idx_o   (out),
    .valid_o (valid),
    .multi_o (multi)
  );

  assign idx_d = out;
  assign vld_d = valid;

  // out is already 2'b00 when nothing is requested, so no extra masking by valid is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= IDX_A0;
      vld_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      vld_q <= vld_d;
    end
  end

  assign out_q   = idx_q;
  assign valid_q = vld_q;

endmodule

// File: tb/tb_enc_4_to_2.sv
// Directed self-checking bench for enc_4_to_2.
module tb_enc_4_to_2;

  logic       clk;
  logic       rst_n;
  logic       a0, a1, a2, a3;
  logic [1:0] out;
  logic       valid;
  logic       multi;
  logic [1:0] out_q;
  logic       valid_q;

  int n_total;
  int n_bad;

  enc_4_to_2 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a0      (a0),
    .a1      (a1),
    .a2      (a2),
    .a3      (a3),
    .out     (out),
    .valid   (valid),
    .multi   (multi),
    .out_q   (out_q),
    .valid_q (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v);
    {a3, a2, a1, a0} = v;
  endtask

  // Directed vectors: inputs {a3,a2,a1,a0}, expected out, valid, multi.
  logic [3:0] vec_in  [9];
  logic [1:0] vec_out [9];
  logic       vec_vld [9];
  logic       vec_mul [9];

  initial begin
    vec_in[0] = 4'b0001; vec_out[0] = 2'b00; vec_vld[0] = 1'b1; vec_mul[0] = 1'b0;
    vec_in[1] = 4'b0010; vec_out[1] = 2'b01; vec_vld[1] = 1'b1; vec_mul[1] = 1'b0;
    vec_in[2] = 4'b0100; vec_out[2] = 2'b10; vec_vld[2] = 1'b1; vec_mul[2] = 1'b0;
    vec_in[3] = 4'b1000; vec_out[3] = 2'b11; vec_vld[3] = 1'b1; vec_mul[3] = 1'b0;
    vec_in[4] = 4'b1010; vec_out[4] = 2'b11; vec_vld[4] = 1'b1; vec_mul[4] = 1'b1;
    vec_in[5] = 4'b0110; vec_out[5] = 2'b10; vec_vld[5] = 1'b1; vec_mul[5] = 1'b1;
    vec_in[6] = 4'b0011; vec_out[6] = 2'b01; vec_vld[6] = 1'b1; vec_mul[6] = 1'b1;
    vec_in[7] = 4'b1111; vec_out[7] = 2'b11; vec_vld[7] = 1'b1; vec_mul[7] = 1'b1;
    vec_in[8] = 4'b1001; vec_out[8] = 2'b11; vec_vld[8] = 1'b1; vec_mul[8] = 1'b1;
  end

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b1;
    drive(4'b0000);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_out_q", {6'd0, out_q}, 8'h00);
    check_eq("rst_valid_q", {7'd0, valid_q}, 8'h00);
    check_eq("idle_out", {6'd0, out}, 8'h00);
    check_eq("idle_valid", {7'd0, valid}, 8'h00);
    check_eq("idle_multi", {7'd0, multi}, 8'h00);

    // Combinational path works while reset is held.
    drive(4'b0100);
    #1 check_eq("comb_in_rst", {6'd0, out}, 8'h02);
    drive(4'b0000);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("idle_q_out", {6'd0, out_q}, 8'h00);
    check_eq("idle_q_valid", {7'd0, valid_q}, 8'h00);

    for (int i = 0; i < 9; i++) begin
      drive(vec_in[i]);
      #5;
      check_eq($sformatf("out_%b", vec_in[i]), {6'd0, out}, {6'd0, vec_out[i]});
      check_eq($sformatf("valid_%b", vec_in[i]), {7'd0, valid}, {7'd0, vec_vld[i]});
      check_eq($sformatf("multi_%b", vec_in[i]), {7'd0, multi}, {7'd0, vec_mul[i]});
    end

    // Registered latency.
    @(negedge clk);
    drive(4'b0000);
    @(posedge clk);
    @(negedge clk);
    drive(4'b0100);
    #1;
    check_eq("lat_before_out_q", {6'd0, out_q}, 8'h00);
    check_eq("lat_before_valid_q", {7'd0, valid_q}, 8'h00);
    @(posedge clk);
    #1;
    check_eq("lat_after_out_q", {6'd0, out_q}, 8'h02);
    check_eq("lat_after_valid_q", {7'd0, valid_q}, 8'h01);

    // Async reset between edges.
    @(negedge clk);
    drive(4'b1000);
    @(posedge clk);
    #1 check_eq("pre_rst_out_q", {6'd0, out_q}, 8'h03);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out_q", {6'd0, out_q}, 8'h00);
    check_eq("arst_valid_q", {7'd0, valid_q}, 8'h00);
    check_eq("arst_comb_out", {6'd0, out}, 8'h03);
    drive(4'b0001);
    #1;
    check_eq("arst_comb_out2", {6'd0, out}, 8'h00);
    check_eq("arst_comb_valid2", {7'd0, valid}, 8'h01);
    @(posedge clk);
    #1;
    check_eq("hold_rst_out_q", {6'd0, out_q}, 8'h00);
    check_eq("hold_rst_valid_q", {7'd0, valid_q}, 8'h00);

    // Release with 0010 pending.
    @(negedge clk);
    drive(4'b0010);
    rst_n = 1'b1;
    #1 check_eq("rel_before_valid_q", {7'd0, valid_q}, 8'h00);
    @(posedge clk);
    #1;
    check_eq("rel_out_q", {6'd0, out_q}, 8'h01);
    check_eq("rel_valid_q", {7'd0, valid_q}, 8'h01);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/enc_4_to_2.md
# enc_4_to_2

Four-input priority encoder with a combinational 2-bit index output and a registered copy for downstream clocked logic. It sits in the request-arbitration path: four single-bit request lines come in, and out the index of the highest active line. The combinational path gives zero-latency decode. The registered path gives a one-cycle-delayed, glitch-free index with a valid flag.

## Interface
Parameters: none. Width is fixed at 4 inputs and 2 index bits.

Ports:
- clk  input  1  system clock; all registered outputs update on the rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- a0  input  1  request line 0 (lowest priority).
- a1  input  1  request line 1.
- a2  input  1  request line 2.
- a3  input  1  request line 3 (highest priority).
- out  output  2  combinational index of the highest asserted request; 2'b00 when none.
- valid  output  1  combinational; 1 when any of a0..a3 is 1.
- multi  output  1  combinational; 1 when two or more of a0..a3 are 1.
- out_q  output  2  registered out.
- valid_q  output  1  registered valid.

## Operation
- Priority rule, highest index wins:
  - a3=1 → out=2'b11
  - else a2=1 → 2'b10
  - else a1=1 → 2'b01
  - else → 2'b00
- a0 alone and no input asserted both give out=2'b00. Software distinguishes the two cases with valid: valid=1 for a0 alone, valid=0 for no input.
- Multi-hot inputs are legal. out follows the priority rule and multi=1.
- out, valid and multi are purely combinational from a0..a3. They do not depend on clk or rst_n and are correct while reset is held.
- Registered path, at each rising clk with rst_n=1: out_q←out and valid_q←valid.
- While valid_q=0, out_q equals 2'b00. This holds because out is 2'b00 whenever valid=0.

## Timing
- Combinational outputs have zero cycles of latency and settle within one propagation delay of an input change.
- out_q and valid_q have one cycle of latency. They reflect the inputs sampled at the previous rising edge.
- Reset values: out_q=2'b00 and valid_q=0.
  - Asserting rst_n low clears out_q and valid_q immediately, with no clock edge required.
  - They stay cleared while rst_n=0.
- Release: the first rising edge after rst_n goes high loads the current inputs.
- Reset asserted mid-operation discards the registered value. Combinational outputs are unaffected.
- Inputs changing in the same cycle are sampled as a set. There is no internal hold or arbitration state.
- No state machine exists; the only state is the 3 flops.

## Structure
- Shared package: constants IDX_W=2 and N_REQ=4, plus index literals IDX_A0..IDX_A3 (2'b00..2'b11) for use by the encoder and its consumers.
- One sub-module is natural: enc_4_to_2_prio, the pure combinational priority encode producing out, valid and multi.
- The top level wraps the sub-module and adds the 3-flop output register with async active-low clear.

## Test plan
- All inputs 0 → out=2'b00, valid=0, multi=0. After one clk edge, out_q=2'b00 and valid_q=0.
- Drive each one-hot input, checking at +5 time units with no clock applied:
  - 0001 → out=2'b00, valid=1
  - 0010 → 2'b01
  - 0100 → 2'b10
  - 1000 → 2'b11
- Multi-hot:
  - 1010 → out=2'b11, multi=1
  - 0110 → out=2'b10, multi=1
  - 0011 → out=2'b01, multi=1
- Registered latency: with rst_n=1, set 0100 just before an edge → out_q=2'b10 and valid_q=1 after that edge, not before.
- Async reset: with out_q=2'b11, drop rst_n between edges → out_q=2'b00 and valid_q=0 immediately, while out still tracks the inputs.
- Release: raise rst_n with inputs at 0010 → the first edge gives out_q=2'b01 and valid_q=1.
